// File: rtl/render_pkg.sv
// ----------------------------------------------------------------------------
// render_pkg
// Shared rendering types and constants used by the sphere scanner.
//   fixed_real : 32.32 signed fixed-point scalar
//   vector     : three fixed_real elements; [0]=x, [1]=depth, [2]=y
//   color      : 24-bit RGB
// Constants: N_SPHERES, SPHERE_RADIUS, BG_COLOR, DEPTH_FAR, scan FSM states.
// ----------------------------------------------------------------------------
package render_pkg;

    localparam int N_SPHERES     = 4;
    localparam int SPHERE_RADIUS = 240;
    localparam int RADIUS_SQ     = SPHERE_RADIUS * SPHERE_RADIUS;

    typedef logic signed [63:0] fixed_real;
    typedef fixed_real [2:0]    vector;
    typedef logic [23:0]        color;
    typedef logic [1:0]         sphere_idx_t;

    localparam color              BG_COLOR  = 24'h000000;
    localparam logic signed [31:0] DEPTH_FAR = 32'sh7FFF_FFFF;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCAN,
        ST_DRAIN,
        ST_DONE
    } scan_state_e;

    // Integer part of a 32.32 value.
    function automatic logic signed [31:0] int_part(input fixed_real v);
        return v[63:32];
    endfunction

    // Magnitude of a 33-bit signed value; -2^32 maps to 2^32, which still
    // fits as an unsigned 33-bit number.
    function automatic logic [32:0] abs33(input logic signed [32:0] v);
        return v[32] ? 33'(-v) : 33'(v);
    endfunction

endpackage

// File: rtl/sphere_scan_if.sv
// ----------------------------------------------------------------------------
// sphere_scan_if
// Bundles the scanner's request/result handshake and the sphere register
// bank read port.
//   master : requester + sphere bank side (drives Start, pixel, sphere data)
//   slave  : the scanner (drives Read_index, Busy, Done and the results)
// ----------------------------------------------------------------------------
interface sphere_scan_if;
    import render_pkg::*;

    // Request
    logic                    Start;
    logic signed [31:0]      Pixel_x;
    logic signed [31:0]      Pixel_y;

    // Sphere register bank read port
    sphere_idx_t             Read_index;
    vector                   Sphere_pos;
    sphere_idx_t             curr_index;
    color [N_SPHERES-1:0]    Sphere_col;

    // Status and result
    logic                    Busy;
    logic                    Done;
    logic                    Hit;
    sphere_idx_t             Hit_index;
    color                    Hit_col;
    logic signed [31:0]      Hit_depth;

    modport master (
        output Start, Pixel_x, Pixel_y, Sphere_pos, curr_index, Sphere_col,
        input  Read_index, Busy, Done, Hit, Hit_index, Hit_col, Hit_depth
    );

    modport slave (
        input  Start, Pixel_x, Pixel_y, Sphere_pos, curr_index, Sphere_col,
        output Read_index, Busy, Done, Hit, Hit_index, Hit_col, Hit_depth
    );

endinterface

// File: rtl/sphere_hit_test.sv
// ----------------------------------------------------------------------------
// sphere_hit_test
// Combinational disk test of a pixel offset against SPHERE_RADIUS.
//   dx_i, dy_i : 33-bit signed offsets sphere - pixel
//   pass_o     : |dx|<=R, |dy|<=R and dx^2+dy^2 <= R^2
// ----------------------------------------------------------------------------
module sphere_hit_test
    import render_pkg::*;
(
    input  logic signed [32:0] dx_i,
    input  logic signed [32:0] dy_i,
    output logic               pass_o
);

    logic [32:0] mag_x;
    logic [32:0] mag_y;
    logic        in_box;
    logic [8:0]  mx;
    logic [8:0]  my;
    logic [17:0] sq_x;
    logic [17:0] sq_y;
    logic [18:0] sum_sq;

    // NOTE: every always_comb output is assigned on every path (here
    // unconditionally) so no latch is inferred.
    always_comb begin
        mag_x  = abs33(dx_i);
        mag_y  = abs33(dy_i);
        in_box = (mag_x <= 33'(SPHERE_RADIUS)) && (mag_y <= 33'(SPHERE_RADIUS));
        // The box check bounds both magnitudes to 240, so 9-bit squares are
        // enough; out-of-box offsets are zeroed so the multipliers stay narrow.
        mx     = in_box ? mag_x[8:0] : 9'd0;
        my     = in_box ? mag_y[8:0] : 9'd0;
        sq_x   = 18'(mx) * 18'(mx);
        sq_y   = 18'(my) * 18'(my);
        sum_sq = 19'(sq_x) + 19'(sq_y);
        pass_o = in_box && (sum_sq <= 19'(RADIUS_SQ));
    end

endmodule

// File: rtl/sphere_scan.sv
// ----------------------------------------------------------------------------
// sphere_scan
// Scans all spheres of the register bank for one latched pixel and reports
// the nearest sphere whose disk covers that pixel.
//   Clk, Reset : clock, asynchronous active-high reset
//   bus        : sphere_scan_if.slave
//                Start/Pixel_x/Pixel_y in, Busy/Done/Hit* out,
//                Read_index out to the bank, Sphere_pos/curr_index/Sphere_col in
// Timeline for a Start accepted at edge N: indices 0..3 issued after N..N+3,
// bank data valid one cycle later, stage 1 one cycle after that, best updated
// at N+3..N+6, Done in the cycle after N+7.
// ----------------------------------------------------------------------------
module sphere_scan
    import render_pkg::*;
(
    input  logic         Clk,
    input  logic         Reset,
    sphere_scan_if.slave bus
);

    scan_state_e        state_q, state_d;
    sphere_idx_t        scan_cnt_q;
    logic signed [31:0] px_q, py_q;

    // Bank data qualifier and stage-1 pipeline
    logic               pos_valid_q;
    logic               s1_valid_q;
    logic signed [32:0] s1_dx_q, s1_dy_q;
    logic signed [31:0] s1_depth_q;
    sphere_idx_t        s1_tag_q;
    logic               last_q;

    // Running best
    logic               best_valid_q;
    sphere_idx_t        best_idx_q;
    logic signed [31:0] best_depth_q;

    // Registered results
    logic               hit_q;
    sphere_idx_t        hit_index_q;
    color               hit_col_q;
    logic signed [31:0] hit_depth_q;

    // Control strobes from the output process
    logic               accept;
    logic               load_result;

    logic               pass;
    logic               better;
    logic signed [31:0] pos_x, pos_y, pos_depth;

    // Fractional parts of the bank positions do not take part in the test.
    logic               unused_frac_bits;
    assign unused_frac_bits = ^{bus.Sphere_pos[0][31:0],
                                bus.Sphere_pos[1][31:0],
                                bus.Sphere_pos[2][31:0]};

    // ---------------- FSM: state register ----------------
    // NOTE: clocked state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of process ordering.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (bus.Start)                             state_d = ST_SCAN;
            ST_SCAN:  if (scan_cnt_q == sphere_idx_t'(N_SPHERES-1)) state_d = ST_DRAIN;
            ST_DRAIN: if (last_q)                                state_d = ST_DONE;
            ST_DONE:                                             state_d = ST_IDLE;
            default:                                             state_d = ST_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        bus.Busy       = (state_q != ST_IDLE);
        bus.Done       = (state_q == ST_DONE);
        bus.Read_index = (state_q == ST_SCAN) ? scan_cnt_q : '0;
        accept         = (state_q == ST_IDLE) && bus.Start;
        // last_q means stage 2 has consumed the final tag, so best is final.
        load_result    = (state_q == ST_DRAIN) && last_q;
    end

    // ---------------- Datapath ----------------
    always_comb begin
        pos_x     = int_part(bus.Sphere_pos[0]);
        pos_depth = int_part(bus.Sphere_pos[1]);
        pos_y     = int_part(bus.Sphere_pos[2]);
    end

    sphere_hit_test u_hit_test (
        .dx_i   (s1_dx_q),
        .dy_i   (s1_dy_q),
        .pass_o (pass)
    );

    // Strictly nearer wins; on equal depth the lower index is kept.
    always_comb begin
        better = !best_valid_q
              || (s1_depth_q < best_depth_q)
              || ((s1_depth_q == best_depth_q) && (s1_tag_q < best_idx_q));
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            scan_cnt_q   <= '0;
            px_q         <= '0;
            py_q         <= '0;
            pos_valid_q  <= 1'b0;
            s1_valid_q   <= 1'b0;
            s1_dx_q      <= '0;
            s1_dy_q      <= '0;
            s1_depth_q   <= '0;
            s1_tag_q     <= '0;
            last_q       <= 1'b0;
            best_valid_q <= 1'b0;
            best_idx_q   <= '0;
            best_depth_q <= DEPTH_FAR;
            hit_q        <= 1'b0;
            hit_index_q  <= '0;
            hit_col_q    <= '0;
            hit_depth_q  <= '0;
        end else begin
            // Issue counter and pixel latch
            if (accept) begin
                scan_cnt_q <= '0;
                px_q       <= bus.Pixel_x;
                py_q       <= bus.Pixel_y;
            end else if (state_q == ST_SCAN) begin
                scan_cnt_q <= scan_cnt_q + 1'b1;
            end

            // The bank answers one cycle after the index is issued.
            pos_valid_q <= (state_q == ST_SCAN);

            // Stage 1: offsets widened to 33 bits so they cannot overflow;
            // the tag comes from the bank, not from the issue counter.
            s1_valid_q <= pos_valid_q;
            if (pos_valid_q) begin
                s1_dx_q    <= {pos_x[31], pos_x} - {px_q[31], px_q};
                s1_dy_q    <= {pos_y[31], pos_y} - {py_q[31], py_q};
                s1_depth_q <= pos_depth;
                s1_tag_q   <= bus.curr_index;
            end

            // Stage 2: best tracking
            if (accept) begin
                best_valid_q <= 1'b0;
                best_idx_q   <= '0;
                best_depth_q <= DEPTH_FAR;
                last_q       <= 1'b0;
            end else if (s1_valid_q) begin
                if (pass && better) begin
                    best_valid_q <= 1'b1;
                    best_idx_q   <= s1_tag_q;
                    best_depth_q <= s1_depth_q;
                end
                if (s1_tag_q == sphere_idx_t'(N_SPHERES-1)) last_q <= 1'b1;
            end

            // Results, captured on the edge that opens the Done cycle and
            // held until the next one.
            if (load_result) begin
                hit_q       <= best_valid_q;
                hit_index_q <= best_valid_q ? best_idx_q : '0;
                hit_col_q   <= best_valid_q ? bus.Sphere_col[best_idx_q] : BG_COLOR;
                hit_depth_q <= best_valid_q ? best_depth_q : DEPTH_FAR;
            end
        end
    end

    assign bus.Hit       = hit_q;
    assign bus.Hit_index = hit_index_q;
    assign bus.Hit_col   = hit_col_q;
    assign bus.Hit_depth = hit_depth_q;

endmodule

// File: tb/tb_sphere_scan.sv
// ----------------------------------------------------------------------------
// tb_sphere_scan
// Directed table of pixel/scene vectors with hand-computed results, plus
// sequences for read-index order, Start during a scan and mid-scan reset.
// ----------------------------------------------------------------------------
module tb_sphere_scan;
    import render_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    sphere_scan_if bus ();

    sphere_scan u_dut (
        .Clk   (clk),
        .Reset (reset),
        .bus   (bus)
    );

    // Sphere register bank model: registered read, one cycle latency.
    vector pos_mem [N_SPHERES];
    always @(posedge clk) begin
        bus.Sphere_pos <= pos_mem[bus.Read_index];
        bus.curr_index <= bus.Read_index;
    end

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic vector mk_pos(input int x, input int y, input int z);
        vector v;
        v[0] = {x, 32'hDEAD_BEEF};
        v[1] = {z, 32'h0000_0000};
        v[2] = {y, 32'h1234_5678};
        return v;
    endfunction

    task automatic load_scene(input int s);
        for (int i = 0; i < N_SPHERES; i++) pos_mem[i] = mk_pos(1000000, 1000000, 1);
        case (s)
            0: pos_mem[0] = mk_pos(2400, -2400, 4800);
            1: begin
                pos_mem[1] = mk_pos(-2400, -2400, 4800);
                pos_mem[2] = mk_pos(-2400, -2400, 9600);
            end
            2: begin
                pos_mem[2] = mk_pos(0, 0, 9600);
                pos_mem[3] = mk_pos(0, 0, 9600);
            end
            default: begin
                pos_mem[0] = mk_pos(0, 0, 100);
                pos_mem[3] = mk_pos(0, 0, -50);
            end
        endcase
    endtask

    // Returns #1 after accepting edge N; the pixel is then disturbed to prove
    // the scanner works from its latched copy.
    task automatic start_scan(input int px, input int py);
        repeat (2) @(negedge clk);
        bus.Pixel_x = px;
        bus.Pixel_y = py;
        bus.Start   = 1'b1;
        @(posedge clk);
        #1;
        bus.Start   = 1'b0;
        bus.Pixel_x = px ^ 32'h5555_0000;
        bus.Pixel_y = py ^ 32'h0000_5555;
    endtask

    // Cycles from the current point until Done is seen; -1 if never.
    task automatic wait_done(output int lat);
        lat = -1;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            if (bus.Done) begin
                lat = k;
                break;
            end
        end
    endtask

    typedef struct {
        int          scene;
        int          px;
        int          py;
        logic        hit;
        logic [1:0]  idx;
        logic [23:0] col;
        logic [31:0] depth;
    } vec_t;

    localparam int N_VEC = 11;
    vec_t vecs [N_VEC];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int ndone;
        int first;

        vecs[0]  = '{0,  2400, -2400, 1'b1, 2'd0, 24'hFF0000, 32'd4800};
        vecs[1]  = '{0,  2640, -2400, 1'b1, 2'd0, 24'hFF0000, 32'd4800};
        vecs[2]  = '{0,  2570, -2230, 1'b0, 2'd0, 24'h000000, 32'h7FFF_FFFF};
        vecs[3]  = '{0,  2160, -2400, 1'b1, 2'd0, 24'hFF0000, 32'd4800};
        vecs[4]  = '{0,  2641, -2400, 1'b0, 2'd0, 24'h000000, 32'h7FFF_FFFF};
        vecs[5]  = '{0,  2400, -2640, 1'b1, 2'd0, 24'hFF0000, 32'd4800};
        vecs[6]  = '{0,  2569, -2231, 1'b1, 2'd0, 24'hFF0000, 32'd4800};
        vecs[7]  = '{1, -2400, -2400, 1'b1, 2'd1, 24'h00FF00, 32'd4800};
        vecs[8]  = '{2,     0,     0, 1'b1, 2'd2, 24'h0000FF, 32'd9600};
        vecs[9]  = '{3,     5,     5, 1'b1, 2'd3, 24'h123456, 32'hFFFF_FFCE};
        vecs[10] = '{0, 32'h8000_0000, -2400, 1'b0, 2'd0, 24'h000000, 32'h7FFF_FFFF};

        bus.Start      = 1'b0;
        bus.Pixel_x    = '0;
        bus.Pixel_y    = '0;
        bus.Sphere_col = {24'h123456, 24'h0000FF, 24'h00FF00, 24'hFF0000};
        load_scene(0);

        // ---- Reset state ----
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy",      32'(bus.Busy),       0);
        check("rst_done",      32'(bus.Done),       0);
        check("rst_hit",       32'(bus.Hit),        0);
        check("rst_hit_index", 32'(bus.Hit_index),  0);
        check("rst_hit_col",   32'(bus.Hit_col),    0);
        check("rst_hit_depth", 32'(bus.Hit_depth),  0);
        check("rst_read_idx",  32'(bus.Read_index), 0);
        @(negedge clk);
        reset = 1'b0;

        // ---- First scan after reset: issue order, Done pulse, hold ----
        load_scene(0);
        start_scan(2400, -2400);
        check("busy_accept", 32'(bus.Busy), 1);
        check("read_idx_n0", 32'(bus.Read_index), 0);
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("read_idx_n%0d", k), 32'(bus.Read_index), (k < 4) ? k : 0);
        end
        wait_done(lat);
        check("done_latency_seq", lat, 3);
        check("busy_in_done", 32'(bus.Busy), 1);
        check("seq_hit_depth", 32'(bus.Hit_depth), 4800);
        @(posedge clk);
        #1;
        check("done_one_cycle", 32'(bus.Done), 0);
        check("busy_after_done", 32'(bus.Busy), 0);
        repeat (3) @(posedge clk);
        #1;
        check("hold_hit", 32'(bus.Hit), 1);
        check("hold_hit_col", 32'(bus.Hit_col), 32'hFF0000);

        // ---- Table-driven vectors ----
        for (int i = 0; i < N_VEC; i++) begin
            load_scene(vecs[i].scene);
            start_scan(vecs[i].px, vecs[i].py);
            wait_done(lat);
            check($sformatf("v%0d_latency", i),   lat, 7);
            check($sformatf("v%0d_hit", i),       32'(bus.Hit),       32'(vecs[i].hit));
            check($sformatf("v%0d_hit_index", i), 32'(bus.Hit_index), 32'(vecs[i].idx));
            check($sformatf("v%0d_hit_col", i),   32'(bus.Hit_col),   32'(vecs[i].col));
            check($sformatf("v%0d_hit_depth", i), bus.Hit_depth,      vecs[i].depth);
        end

        // ---- Start pulsed again at N+3 is ignored ----
        load_scene(1);
        start_scan(-2400, -2400);
        ndone = 0;
        first = -1;
        repeat (2) @(posedge clk);
        #1;
        bus.Start   = 1'b1;
        bus.Pixel_x = 2400;
        bus.Pixel_y = -2400;
        @(posedge clk);
        #1;
        bus.Start = 1'b0;
        for (int k = 4; k <= 22; k++) begin
            @(posedge clk);
            #1;
            if (bus.Done) begin
                ndone++;
                if (first < 0) first = k;
            end
        end
        check("restart_done_count", ndone, 1);
        check("restart_latency", first, 7);
        check("restart_hit_index", 32'(bus.Hit_index), 1);
        check("restart_hit_depth", bus.Hit_depth, 4800);

        // ---- Reset at N+4 aborts the scan ----
        load_scene(0);
        start_scan(2400, -2400);
        repeat (4) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("abort_busy",      32'(bus.Busy),       0);
        check("abort_done",      32'(bus.Done),       0);
        check("abort_hit",       32'(bus.Hit),        0);
        check("abort_hit_index", 32'(bus.Hit_index),  0);
        check("abort_hit_col",   32'(bus.Hit_col),    0);
        check("abort_hit_depth", 32'(bus.Hit_depth),  0);
        check("abort_read_idx",  32'(bus.Read_index), 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        ndone = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk);
            #1;
            if (bus.Done) ndone++;
        end
        check("abort_no_done", ndone, 0);
        check("abort_idle", 32'(bus.Busy), 0);

        // ---- First Start after that reset is accepted ----
        load_scene(2);
        start_scan(0, 0);
        wait_done(lat);
        check("post_rst_latency", lat, 7);
        check("post_rst_hit_index", 32'(bus.Hit_index), 2);
        check("post_rst_hit_col", 32'(bus.Hit_col), 32'h0000FF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
